// File: rtl/conv_window_gen.sv
// 3x3 window generator: raster pixels into four rotating line buffers, one registered 72-bit window per cycle.
// Optional CONV_WINDOW_BORDER_REPLICATE_EN: full-width rows with horizontal edge clamping instead of valid-region only.
module conv_window_gen #(
  parameter int IMG_WIDTH = 512,
  parameter int CNT_W     = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic        o_in_ready,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);

  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(IMG_WIDTH - 1);
`ifdef CONV_WINDOW_BORDER_REPLICATE_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(IMG_WIDTH - 1);
`else
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(IMG_WIDTH - 3);
`endif

  typedef enum logic {IDLE, RD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       wr_buf_q, wr_buf_d;
  logic [1:0]       rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] wr_col_q, wr_col_d;
  logic [CNT_W-1:0] rd_col_q, rd_col_d;
  logic [2:0]       lines_q, lines_d;
  logic [71:0]      pix_q, pix_d;
  logic             vld_q, intr_q;

  logic             wr_en, line_done, issue, retire;
  logic [AW-1:0]    col_l, col_m, col_r;
  logic [1:0]       buf_a, buf_b, buf_c;

  logic [7:0] mem [0:3][0:IMG_WIDTH-1];

  assign o_in_ready         = (lines_q < 3'd4);
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = vld_q;
  assign o_intr             = intr_q;

  assign wr_en     = i_pixel_data_valid && o_in_ready;
  assign line_done = wr_en && (wr_col_q == WR_LAST);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_buf_q][wr_col_q[AW-1:0]] <= i_pixel_data;
  end

  always_comb begin
    wr_col_d = wr_col_q;
    wr_buf_d = wr_buf_q;
    if (wr_en) begin
      if (line_done) begin
        wr_col_d = '0;
        wr_buf_d = wr_buf_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + CNT_W'(1);
      end
    end
  end

  // A completion and a retire in the same cycle cancel out.
  assign lines_d = lines_q + {2'b00, line_done} - {2'b00, retire};

  always_comb begin
    state_d  = state_q;
    rd_col_d = rd_col_q;
    rd_buf_d = rd_buf_q;
    issue    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lines_q >= 3'd3) state_d = RD;
      end
      RD: begin
        issue = 1'b1;
        if (rd_col_q == RD_LAST) begin
          rd_col_d = '0;
          rd_buf_d = rd_buf_q + 2'd1;
          retire   = 1'b1;
          state_d  = IDLE;
        end else begin
          rd_col_d = rd_col_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CONV_WINDOW_BORDER_REPLICATE_EN
  // Centre on rd_col; edge neighbours replicate the outermost pixel.
  always_comb begin
    col_m = rd_col_q[AW-1:0];
    col_l = (rd_col_q == '0) ? col_m : col_m - AW'(1);
    col_r = (rd_col_q == RD_LAST) ? col_m : col_m + AW'(1);
  end
`else
  always_comb begin
    col_l = rd_col_q[AW-1:0];
    col_m = col_l + AW'(1);
    col_r = col_l + AW'(2);
  end
`endif

  assign buf_a = rd_buf_q;
  assign buf_b = rd_buf_q + 2'd1;
  assign buf_c = rd_buf_q + 2'd2;

  assign pix_d = {mem[buf_c][col_r], mem[buf_c][col_m], mem[buf_c][col_l],
                  mem[buf_b][col_r], mem[buf_b][col_m], mem[buf_b][col_l],
                  mem[buf_a][col_r], mem[buf_a][col_m], mem[buf_a][col_l]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_buf_q <= '0;
      wr_col_q <= '0;
      rd_buf_q <= '0;
      rd_col_q <= '0;
      lines_q  <= '0;
      pix_q    <= '0;
      vld_q    <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_buf_q <= wr_buf_d;
      wr_col_q <= wr_col_d;
      rd_buf_q <= rd_buf_d;
      rd_col_q <= rd_col_d;
      lines_q  <= lines_d;
      vld_q    <= issue;
      intr_q   <= retire;
      if (issue) pix_q <= pix_d;
    end
  end

endmodule
